// File: rtl/rv_fetch_bus_resp_pkg.sv
// Shared definitions for the instruction-side fetch bus responder.
// Holds the responder state encoding, the wait-state counter width and a
// small alignment helper, so the memory model and bench can reuse them.
package rv_fetch_bus_resp_pkg;

  // Width of the programmable wait-state counter (WAIT_STATES is 0..15).
  localparam int WS_W   = 4;
  // Instruction word width on both the fetch bus and the memory port.
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  // A fetch is misaligned when either of the two byte-offset bits is set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/rv_fetch_bus_resp.sv
// rv_fetch_bus_resp: fetch-stage bus responder.
// Accepts one fetch at a time, inserts WAIT_STATES idle cycles, then issues
// a word-addressed read on the memory port (req/gnt, then rvalid) and returns
// the instruction with a single-cycle registered acknowledge. A flush from a
// taken branch/jump abandons the in-flight fetch without acknowledging it;
// if the memory already owes a beat, the DRAIN state swallows it.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset
//   i_req/i_addr  fetch request and byte address (held until o_ack)
//   i_flush       discard the current fetch
//   o_ack         one-cycle pulse, qualifies o_rdata/o_err
//   o_rdata       instruction word (holds between acks)
//   o_err         misaligned fetch, valid with o_ack
//   o_busy        responder not idle
//   o_mem_req     memory request, decoded from state
//   o_mem_addr    latched word address
//   i_mem_gnt     memory accepted the request
//   i_mem_rvalid  read data valid
//   i_mem_rdata   read data
module rv_fetch_bus_resp
  import rv_fetch_bus_resp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-3:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);
  localparam logic [WS_W-1:0] WS_ZERO = {WS_W{1'b0}};
  localparam logic [WS_W-1:0] WS_ONE  = {{(WS_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_r, state_s;
  logic [WS_W-1:0]   cnt_r, cnt_s;
  logic [ADDR_W-3:0] addr_r, addr_s;
  logic              ack_r, ack_s;
  logic              err_r, err_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              accept_s;

  // A request seen while the previous ack is still on the bus is the same
  // request, so it must not be taken again; a flush also blocks acceptance.
  assign accept_s = i_req & ~ack_r & ~i_flush;

  // Next-state and next-output decode for the fetch responder.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    ack_s   = 1'b0;
    err_s   = 1'b0;
    rdata_s = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          addr_s = i_addr[ADDR_W-1:2];
          if (is_misaligned(i_addr[1:0])) begin
            // Answer directly from IDLE: no memory access at all.
            ack_s   = 1'b1;
            err_s   = 1'b1;
            rdata_s = {DATA_W{1'b0}};
          end else if (WS_INIT == WS_ZERO) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WS_INIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_flush) begin
          state_s = ST_IDLE;
          cnt_s   = WS_ZERO;
        end else begin
          cnt_s = cnt_r - WS_ONE;
          if (cnt_r == WS_ONE) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          // Once granted, the memory owes a beat; a flush must drain it.
          state_s = i_flush ? ST_DRAIN : ST_RESP;
        end else if (i_flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (i_mem_rvalid) begin
          state_s = ST_IDLE;
          if (i_flush) begin
            rdata_s = rdata_r;
          end else begin
            ack_s   = 1'b1;
            rdata_s = i_mem_rdata;
          end
        end else if (i_flush) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DRAIN: begin
        // Flush is meaningless here: the beat is dropped regardless.
        if (i_mem_rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = WS_ZERO;
      end
    endcase
  end

  // State, counter, latched address and registered response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= WS_ZERO;
      addr_r  <= {(ADDR_W-2){1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      rdata_r <= rdata_s;
    end
  end

  assign o_ack      = ack_r;
  assign o_err      = err_r;
  assign o_rdata    = rdata_r;
  assign o_mem_addr = addr_r;
  assign o_busy     = (state_r != ST_IDLE);
  assign o_mem_req  = (state_r == ST_REQ);

endmodule

// File: tb/tb_rv_fetch_bus_resp.sv
// Self-checking bench for rv_fetch_bus_resp. Two instances (WAIT_STATES 0
// and 2) are exercised one at a time by a single driver. The driver walks
// each fetch through its timeline (accept, wait states, request/grant,
// response, ack) and records what every output must be in each cycle; one
// compare process checks all outputs of both instances every cycle and pins
// ack latency, memory-request cycles and ack payload against literal values.
module tb_rv_fetch_bus_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [2];
  logic        req_a  [2];
  logic        fl_a   [2];
  logic        gnt_a  [2];
  logic        rv_a   [2];
  logic [31:0] addr_a [2];
  logic [31:0] mrd_a  [2];

  logic        ack0, err0, busy0, mreq0, ack1, err1, busy1, mreq1;
  logic [31:0] rdata0, rdata1;
  logic [29:0] maddr0, maddr1;

  // expected outputs for the current cycle, per instance
  logic        e_ack [2], e_err [2], e_busy [2], e_mreq [2];
  logic [31:0] e_rdata [2];
  logic [29:0] e_maddr [2];
  // model: last returned word and last latched word address
  logic [31:0] m_rdata [2];
  logic [29:0] m_maddr [2];

  // pinned per-fetch expectations, checked when the ack appears
  bit          lat_pend [2];
  int          lat_exp  [2];
  int          mreq_exp [2];
  int          mreq_cnt [2];
  int          acc_cyc  [2];
  logic [31:0] pin_rdata[2];
  logic        pin_err  [2];
  logic [29:0] pin_maddr[2];

  bit chk_on = 1'b0;
  int cyc    = 0;
  int total  = 0;
  int bad    = 0;

  rv_fetch_bus_resp #(.ADDR_W(32), .WAIT_STATES(0)) u_dut_ws0 (
    .i_clk(clk), .i_reset(rst_a[0]), .i_req(req_a[0]), .i_addr(addr_a[0]),
    .i_flush(fl_a[0]), .o_ack(ack0), .o_rdata(rdata0), .o_err(err0),
    .o_busy(busy0), .o_mem_req(mreq0), .o_mem_addr(maddr0),
    .i_mem_gnt(gnt_a[0]), .i_mem_rvalid(rv_a[0]), .i_mem_rdata(mrd_a[0])
  );

  rv_fetch_bus_resp #(.ADDR_W(32), .WAIT_STATES(2)) u_dut_ws2 (
    .i_clk(clk), .i_reset(rst_a[1]), .i_req(req_a[1]), .i_addr(addr_a[1]),
    .i_flush(fl_a[1]), .o_ack(ack1), .o_rdata(rdata1), .o_err(err1),
    .o_busy(busy1), .o_mem_req(mreq1), .o_mem_addr(maddr1),
    .i_mem_gnt(gnt_a[1]), .i_mem_rvalid(rv_a[1]), .i_mem_rdata(mrd_a[1])
  );

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s[ws%0d] actual=%0h expected=%0h cycle=%0d", nm, k * 2, act, exp_v, cyc);
    end
  endtask

  // compare process: all outputs every cycle, plus pinned per-fetch checks
  initial begin
    logic        a_ack, a_err, a_busy, a_mreq;
    logic [31:0] a_rd;
    logic [29:0] a_ma;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int k = 0; k < 2; k++) begin
          a_ack  = (k == 0) ? ack0   : ack1;
          a_err  = (k == 0) ? err0   : err1;
          a_busy = (k == 0) ? busy0  : busy1;
          a_mreq = (k == 0) ? mreq0  : mreq1;
          a_rd   = (k == 0) ? rdata0 : rdata1;
          a_ma   = (k == 0) ? maddr0 : maddr1;
          cmp("ack",      k, {31'd0, a_ack},  {31'd0, e_ack[k]});
          cmp("err",      k, {31'd0, a_err},  {31'd0, e_err[k]});
          cmp("busy",     k, {31'd0, a_busy}, {31'd0, e_busy[k]});
          cmp("mem_req",  k, {31'd0, a_mreq}, {31'd0, e_mreq[k]});
          cmp("rdata",    k, a_rd,            e_rdata[k]);
          cmp("mem_addr", k, {2'b00, a_ma},   {2'b00, e_maddr[k]});
          if (lat_pend[k]) begin
            if (a_mreq) mreq_cnt[k]++;
            if (a_ack) begin
              cmp("latency",      k, 32'(cyc - acc_cyc[k]), 32'(lat_exp[k]));
              cmp("mem_req_cyc",  k, 32'(mreq_cnt[k]),      32'(mreq_exp[k]));
              cmp("pin_rdata",    k, a_rd,                  pin_rdata[k]);
              cmp("pin_err",      k, {31'd0, a_err},        {31'd0, pin_err[k]});
              cmp("pin_mem_addr", k, {2'b00, a_ma},         {2'b00, pin_maddr[k]});
              lat_pend[k] = 1'b0;
              mreq_cnt[k] = 0;
            end else if (cyc - acc_cyc[k] > lat_exp[k] + 2) begin
              cmp("ack_timeout", k, 32'd0, 32'd1);
              lat_pend[k] = 1'b0;
              mreq_cnt[k] = 0;
            end
          end
        end
      end
      cyc++;
    end
  end

  // one cycle: drive inputs of instance k and state what its outputs must be
  task automatic step(input int k, input logic r, input logic [31:0] a, input logic f,
                      input logic g, input logic rv, input logic [31:0] md,
                      input logic ea, input logic ee, input logic eb, input logic em);
    req_a[k] = r; addr_a[k] = a; fl_a[k] = f; gnt_a[k] = g; rv_a[k] = rv; mrd_a[k] = md;
    e_ack[k] = ea; e_err[k] = ee; e_busy[k] = eb; e_mreq[k] = em;
    e_rdata[k] = m_rdata[k];
    e_maddr[k] = m_maddr[k];
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic arm(input int k, input int lat, input int nreq, input logic [31:0] d,
                     input logic e, input logic [29:0] ma);
    lat_exp[k] = lat; mreq_exp[k] = nreq; pin_rdata[k] = d; pin_err[k] = e;
    pin_maddr[k] = ma; mreq_cnt[k] = 0; acc_cyc[k] = cyc; lat_pend[k] = 1'b1;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, $urandom(), rbit(), 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // beat owed after a flush: dd quiet cycles then the dropped beat; the
  // next request (nxt) is already presented and must not be taken
  task automatic drain(input int k, input int dd, input logic [31:0] nxt);
    for (int i = 0; i < dd; i++) step(k, 1'b1, nxt, rbit(), 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
    step(k, 1'b1, nxt, rbit(), 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // One fetch. gd = grant stall cycles, rd = extra rvalid delay cycles,
  // pf = cycles the request is blocked by flush in idle, fl = flush point:
  // 1 in first wait state, 2 in first stalled request cycle, 3 with grant,
  // 4 in first response cycle (then drain rd cycles), 5 with rvalid.
  task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input int gd,
                     input int rd, input int fl, input int pf, input logic [31:0] nxt);
    int ws;
    ws = (k == 0) ? 0 : 2;
    for (int i = 0; i < pf; i++) step(k, 1'b1, a, 1'b1, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    acc_cyc[k] = cyc;
    step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    m_maddr[k] = a[31:2];
    if (a[1:0] != 2'b00) begin
      m_rdata[k] = 32'h0;
      step(k, 1'b1, a, rbit(), 1'b0, 1'b0, $urandom(), 1'b1, 1'b1, 1'b0, 1'b0);
      return;
    end
    for (int i = 0; i < ws; i++) begin
      if (fl == 1 && i == 0) begin
        step(k, 1'b1, a, 1'b1, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
        return;
      end
      step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < gd; i++) begin
      if (fl == 2 && i == 0) begin
        step(k, 1'b1, a, 1'b1, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
        return;
      end
      step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    if (fl == 3) begin
      step(k, 1'b1, a, 1'b1, 1'b1, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
      drain(k, rd, nxt);
      return;
    end
    step(k, 1'b1, a, 1'b0, 1'b1, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
    if (fl == 4) begin
      step(k, 1'b1, a, 1'b1, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
      drain(k, rd, nxt);
      return;
    end
    for (int i = 0; i < rd; i++) step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
    if (fl == 5) begin
      step(k, 1'b1, a, 1'b1, 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
      return;
    end
    step(k, 1'b1, a, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
    m_rdata[k] = d;
    // ack cycle: request still high (must be ignored), flush must not cancel it
    step(k, 1'b1, a, rbit(), 1'b0, 1'b0, $urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // fetch reset while waiting for rvalid, with rvalid during and after reset
  task automatic rst_mid(input int k, input logic [31:0] a);
    int ws;
    ws = (k == 0) ? 0 : 2;
    step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    m_maddr[k] = a[31:2];
    for (int i = 0; i < ws; i++) step(k, 1'b1, a, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
    step(k, 1'b1, a, 1'b0, 1'b1, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1, 1'b1);
    rst_a[k] = 1'b1;
    step(k, 1'b1, a, 1'b0, 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b1, 1'b0);
    m_rdata[k] = 32'h0;
    m_maddr[k] = 30'h0;
    step(k, 1'b1, a, 1'b0, 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    rst_a[k] = 1'b0;
    step(k, 1'b0, a, 1'b0, 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(k, 2);
  endtask

  initial begin
    int k, ws, gd, rd, fl, pf;
    logic [31:0] a, d;
    bit eff;
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; req_a[i] = 1'b0; fl_a[i] = 1'b0; gnt_a[i] = 1'b0; rv_a[i] = 1'b0;
      addr_a[i] = 32'h0; mrd_a[i] = 32'h0; m_rdata[i] = 32'h0; m_maddr[i] = 30'h0;
      e_ack[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0; e_mreq[i] = 1'b0;
      e_rdata[i] = 32'h0; e_maddr[i] = 30'h0; lat_pend[i] = 1'b0; mreq_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    step(0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    idle(0, 1);

    // no wait states, immediate grant/rvalid
    arm(0, 3, 1, 32'h0000_0013, 1'b0, 30'h40);
    txn(0, 32'h0000_0100, 32'h0000_0013, 0, 0, 0, 0, 32'h0);
    // misaligned fetch, back-to-back with the previous ack
    arm(0, 1, 0, 32'h0, 1'b1, 30'h40);
    txn(0, 32'h0000_0102, 32'h0, 0, 0, 0, 0, 32'h0);
    idle(0, 1);
    // flush together with rvalid, then a fresh request completes
    txn(0, 32'h0000_0040, 32'h5555_AAAA, 0, 1, 5, 0, 32'h0);
    arm(0, 3, 1, 32'h00A0_0093, 1'b0, 30'h11);
    txn(0, 32'h0000_0044, 32'h00A0_0093, 0, 0, 0, 0, 32'h0);
    idle(0, 1);
    // reset while waiting for rvalid, then a normal fetch
    rst_mid(0, 32'h0000_0080);
    arm(0, 3, 1, 32'h1234_5678, 1'b0, 30'h30);
    txn(0, 32'h0000_00C0, 32'h1234_5678, 0, 0, 0, 0, 32'h0);
    idle(0, 1);

    // two wait states, grant after 3 stall cycles, rvalid 2 cycles after grant
    arm(1, 9, 4, 32'hDEAD_BEEF, 1'b0, 30'h100);
    txn(1, 32'h0000_0400, 32'hDEAD_BEEF, 3, 1, 0, 0, 32'h0);
    idle(1, 1);
    // flush in RESP before rvalid; 0x200 presented during drain
    txn(1, 32'h0000_0300, 32'hBAD0_BAD0, 0, 2, 4, 0, 32'h0000_0200);
    arm(1, 5, 1, 32'hCAFE_0001, 1'b0, 30'h80);
    txn(1, 32'h0000_0200, 32'hCAFE_0001, 0, 0, 0, 0, 32'h0);
    idle(1, 1);
    // flush in idle blocks acceptance for two cycles
    arm(1, 5, 1, 32'h0BAD_F00D, 1'b0, 30'h3);
    txn(1, 32'h0000_000C, 32'h0BAD_F00D, 0, 0, 0, 2, 32'h0);
    idle(1, 1);

    // randomized fetches against the timeline model
    for (int n = 0; n < 120; n++) begin
      k  = $urandom_range(0, 1);
      ws = (k == 0) ? 0 : 2;
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      pf = $urandom_range(0, 1);
      fl = $urandom_range(0, 9);
      d  = $urandom();
      a  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (fl > 5 || a[1:0] != 2'b00) fl = 0;
      eff = (fl == 1 && ws > 0) || (fl == 2 && gd > 0) || (fl >= 3);
      if (a[1:0] != 2'b00) arm(k, 1, 0, 32'h0, 1'b1, a[31:2]);
      else if (!eff) arm(k, 3 + ws + gd + rd, gd + 1, d, 1'b0, a[31:2]);
      txn(k, a, d, gd, rd, fl, pf, $urandom());
      idle(k, 1 + $urandom_range(0, 2));
    end

    idle(0, 4);
    idle(1, 4);
    chk_on = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
